lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- MEM-stage load/store initiator for the 5-stage core; the requesting end of the data-memory interface (op, addr, data_in, we, data_out).
- Accepts one load/store per request from the pipeline and drives the data-memory unit's port with registered signals.
- Splits misaligned accesses into byte accesses, reassembles load data, and returns a registered response.
- Pipeline stalls on ready=0.

Parameters:
- ADDR_WIDTH, 15, byte-address width of the data-memory port; request address truncated to this.
- DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous and active-low
- req_valid  in  1  pipeline presents an access
- ready  out  1  block can accept; a request is accepted when req_valid & ready at a clk edge
- req_we  in  1  1=store, 0=load
- req_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle pulse, access complete
- resp_err  out  1  valid with resp_valid; illegal/misaligned access
- resp_rdata  out  32  load result, extended; 0 for stores/errors
- mem_op  out  3  op to data memory
- mem_addr  out  ADDR_WIDTH  byte address to data memory
- mem_data_in  out  32  write data to data memory
- mem_we  out  1  write enable to data memory
- mem_data_out  in  32  read data from data memory, valid the cycle after the access cycle

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE.
  - ready=1; resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_we=0, mem_op=0, mem_addr=0, mem_data_in=0.
  - A reset mid-transaction aborts it: no response, and no further mem_we pulses after that edge.
- States: IDLE, ACCESS, DRAIN. ready=1 only in IDLE.
- Accept at cycle T:
  - Capture op/we/addr/wdata.
  - Classify the access:
    - Illegal: op 011/110/111, or a store with op 100/101.
    - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
    - Aligned: everything else.
- Illegal: no memory access; resp_valid=1, resp_err=1, rdata=0 at T+1; IDLE.
- Aligned access (N=1):
  - T+1 (ACCESS): mem_op=req_op, mem_addr=addr[ADDR_WIDTH-1:0], mem_data_in=wdata, mem_we=req_we.
  - Store: resp_valid at T+2.
  - Load: DRAIN at T+2, mem_data_out sampled; resp_valid with resp_rdata=mem_data_out at T+3. The memory performs extension.
- Misaligned access (see feature): N byte accesses, N=2 for H/HU and N=4 for W, in ACCESS cycles T+1..T+N.
  - Byte k uses mem_addr=addr+k, wrapping modulo 2^ADDR_WIDTH.
  - Store: mem_op=000, mem_data_in[7:0]=wdata byte k, upper bits 0, mem_we=1 each cycle; resp_valid at T+N+1.
  - Load: mem_op=100, mem_we=0. Byte k is sampled at T+k+1 from mem_data_out[7:0] and assembled little-endian. H sign-extends from bit 15; HU zero-extends. resp_valid at T+N+2.
- Outside ACCESS cycles: mem_we=0, mem_op=0, mem_addr=0, mem_data_in=0.
- Response handling:
  - resp_valid is a single-cycle pulse.
  - The state is IDLE in the resp_valid cycle, so ready=1 and back-to-back accepts are allowed.
  - resp_err=0 for every successful access.
- req_* are ignored while ready=0.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are split as above.
- Undefined: misaligned accesses are treated as illegal: no memory access, resp_err=1 at T+1, and the split datapath is not built.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> ready=1, mem_we=0, resp_valid=0. Assert rst_n=0 during the 2nd ACCESS cycle of a misaligned SW -> no resp, mem_we=0 from the next cycle.
- Aligned SW addr 0x10 wdata 0xDEADBEEF at T -> T+1: mem_we=1, mem_op=010, mem_addr=0x10; resp_valid at T+2. Then LW 0x10 accepted at T+2 -> resp_rdata=0xDEADBEEF at T+5.
- Aligned LB addr 0x13, memory returning 0xFFFFFF80 -> resp_rdata=0xFFFFFF80, resp_err=0, resp_valid 3 cycles after accept.
- Misaligned SW addr 0x0005 wdata 0x11223344 (LSU_MISALIGN_SPLIT_EN) -> 4 SB cycles: 0x44@5, 0x33@6, 0x22@7, 0x11@8; resp_valid at T+5. Without the macro -> resp_err=1 at T+1, no mem_we.
- Misaligned LH addr 0x7FFF (wrap), bytes [0x7FFF]=0xF0, [0x0000]=0x80 -> mem_addr 0x7FFF then 0x0000; resp_rdata=0xFFFF80F0 at T+4. LHU on the same bytes -> 0x000080F0.
- Illegal op 011 load, and SB-type store with op 100 -> resp_valid=1, resp_err=1, resp_rdata=0 at T+1, no memory access, ready=1 at T+1.

Source files
------------

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator: drives one registered access onto the data-memory port, returns a registered response.
// Build option LSU_MISALIGN_SPLIT_EN: split misaligned H/HU/W into byte accesses instead of rejecting them.
module lsu_mem_initiator #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  ready,
    input  logic                  req_we,
    input  logic [2:0]            req_op,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [2:0]            mem_op,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DRAIN} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_we;
    logic [2:0]              r_mem_op, w_mem_op_nxt;
    logic [ADDR_WIDTH-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_mem_data, w_mem_data_nxt;
    logic                    r_mem_we, w_mem_we_nxt;
    logic                    r_resp_valid, w_resp_valid_nxt;
    logic                    r_resp_err, w_resp_err_nxt;
    logic [DATA_WIDTH-1:0]   r_resp_rdata, w_resp_rdata_nxt;
    logic                    w_accept, w_illegal, w_misal, w_reject;
    logic                    w_unused;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [2:0] OP_SB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b100;
    logic [2:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_split;
    logic [1:0]            r_cnt, r_last, w_cnt_nxt, w_cnt_inc;
    logic [23:0]           r_asm, w_asm_nxt;

    assign w_cnt_inc = r_cnt + 2'd1;
`endif

    assign ready     = (r_state == S_IDLE);
    assign w_accept  = req_valid & ready;
    assign w_illegal = (req_op == 3'b011) || (req_op[2:1] == 2'b11) || (req_we && req_op[2]);
    assign w_misal   = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_op == 3'b010) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_reject  = w_illegal;
`else
    assign w_reject  = w_illegal | w_misal;
`endif
    assign w_unused  = ^req_addr[31:ADDR_WIDTH];

    assign mem_op      = r_mem_op;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data;
    assign mem_we      = r_mem_we;
    assign resp_valid  = r_resp_valid;
    assign resp_err    = r_resp_err;
    assign resp_rdata  = r_resp_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Memory-port values are computed one cycle ahead so the port itself is registered.
    always_comb begin
        w_state_nxt      = r_state;
        w_mem_op_nxt     = 3'b000;
        w_mem_addr_nxt   = '0;
        w_mem_data_nxt   = '0;
        w_mem_we_nxt     = 1'b0;
        w_resp_valid_nxt = 1'b0;
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
        w_cnt_nxt        = r_cnt;
        w_asm_nxt        = r_asm;
`endif
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_reject) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt    = S_ACCESS;
                        w_mem_op_nxt   = req_op;
                        w_mem_addr_nxt = req_addr[ADDR_WIDTH-1:0];
                        w_mem_data_nxt = req_wdata;
                        w_mem_we_nxt   = req_we;
`ifdef LSU_MISALIGN_SPLIT_EN
                        w_cnt_nxt = 2'd0;
                        if (w_misal) begin
                            w_mem_op_nxt   = req_we ? OP_SB : OP_LBU;
                            w_mem_data_nxt = {{(DATA_WIDTH-8){1'b0}}, req_wdata[7:0]};
                        end
`endif
                    end
                end
            end
            S_ACCESS: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                // Byte cnt-1 read in the previous cycle is on mem_data_out now.
                if (r_split && !r_we) begin
                    case (r_cnt)
                        2'd1:    w_asm_nxt[7:0]   = mem_data_out[7:0];
                        2'd2:    w_asm_nxt[15:8]  = mem_data_out[7:0];
                        2'd3:    w_asm_nxt[23:16] = mem_data_out[7:0];
                        default: ;
                    endcase
                end
                if (r_cnt != r_last) begin
                    w_cnt_nxt      = w_cnt_inc;
                    w_mem_op_nxt   = r_we ? OP_SB : OP_LBU;
                    w_mem_addr_nxt = r_addr + ADDR_WIDTH'(w_cnt_inc);
                    w_mem_data_nxt = {{(DATA_WIDTH-8){1'b0}}, r_wdata[{w_cnt_inc, 3'b000} +: 8]};
                    w_mem_we_nxt   = r_we;
                end else if (r_we) begin
                    w_resp_valid_nxt = 1'b1;
                    w_state_nxt      = S_IDLE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
`else
                if (r_we) begin
                    w_resp_valid_nxt = 1'b1;
                    w_state_nxt      = S_IDLE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
`endif
            end
            S_DRAIN: begin
                w_state_nxt      = S_IDLE;
                w_resp_valid_nxt = 1'b1;
                w_resp_rdata_nxt = mem_data_out;
`ifdef LSU_MISALIGN_SPLIT_EN
                if (r_split) begin
                    if (r_op[1])
                        w_resp_rdata_nxt = {mem_data_out[7:0], r_asm[23:0]};
                    else if (r_op[2])
                        w_resp_rdata_nxt = {16'h0000, mem_data_out[7:0], r_asm[7:0]};
                    else
                        w_resp_rdata_nxt = {{16{mem_data_out[7]}}, mem_data_out[7:0], r_asm[7:0]};
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_mem_op     <= 3'b000;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_op    <= 3'b000;
            r_addr  <= '0;
            r_wdata <= '0;
            r_split <= 1'b0;
            r_cnt   <= 2'd0;
            r_last  <= 2'd0;
            r_asm   <= '0;
`endif
        end else begin
            r_mem_op     <= w_mem_op_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_data   <= w_mem_data_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            if (w_accept) r_we <= req_we;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (w_accept) begin
                r_op    <= req_op;
                r_addr  <= req_addr[ADDR_WIDTH-1:0];
                r_wdata <= req_wdata;
                r_split <= w_misal;
                r_last  <= w_misal ? (req_op[1] ? 2'd3 : 2'd1) : 2'd0;
            end
            r_cnt <= w_cnt_nxt;
            r_asm <= w_asm_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: byte-array data memory, directed cases and random traffic against a per-request reference.
`timescale 1ns/1ps
module tb_lsu_mem_initiator;
    localparam int AW = 15;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, req_valid, ready, req_we, resp_valid, resp_err, mem_we;
    logic [2:0]  req_op, mem_op;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_data_in, mem_data_out;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .ready(ready),
        .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we),
        .mem_data_out(mem_data_out)
    );

    logic [7:0]  mem_b   [0:(1<<AW)-1];
    logic [7:0]  ref_mem [0:(1<<AW)-1];
    bit          mem_inited = 1'b0;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] log_addr [0:15];
    logic [31:0] log_data [0:15];
    logic [2:0]  log_op   [0:15];
    logic        log_we   [0:15];
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Data memory: registered read with extension by op, byte/half/word writes.
    function automatic logic [31:0] mem_rd(input logic [2:0] op, input logic [AW-1:0] a);
        logic [31:0] w;
        w = {mem_b[AW'(a + 3)], mem_b[AW'(a + 2)], mem_b[AW'(a + 1)], mem_b[a]};
        case (op)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < (1 << AW); i++) mem_b[i] <= 8'h00;
            mem_inited <= 1'b1;
        end else begin
            mem_data_out <= mem_rd(mem_op, mem_addr);
            if (mem_we) begin
                mem_b[mem_addr] <= mem_data_in[7:0];
                if (mem_op[1:0] != 2'b00) mem_b[AW'(mem_addr + 1)] <= mem_data_in[15:8];
                if (mem_op[1:0] == 2'b10) begin
                    mem_b[AW'(mem_addr + 2)] <= mem_data_in[23:16];
                    mem_b[AW'(mem_addr + 3)] <= mem_data_in[31:24];
                end
            end
        end
    end

    // Reference: what a request must produce (error, data, latency, write cycles) and its effect on memory.
    function automatic void ref_model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                      input logic [31:0] wd, output logic err, output logic [31:0] rd,
                                      output int lat, output int nwe);
        int nb;
        bit illegal, mis;
        logic [AW-1:0] a;
        logic [31:0] v;
        illegal = (op == 3'd3) || (op == 3'd6) || (op == 3'd7) || (we && op[2]);
        nb  = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        mis = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
        a = addr[AW-1:0];
        err = 1'b0; rd = 32'h0; lat = 0; nwe = 0;
        if (illegal || (mis && !SPLIT)) begin
            err = 1'b1;
            lat = 1;
        end else if (we) begin
            for (int k = 0; k < nb; k++) ref_mem[AW'(a + k)] = wd[8*k +: 8];
            nwe = mis ? nb : 1;
            lat = mis ? nb + 1 : 2;
        end else begin
            v = 32'h0;
            for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[AW'(a + k)];
            if (!op[2] && nb == 1) v = {{24{v[7]}}, v[7:0]};
            if (!op[2] && nb == 2) v = {{16{v[15]}}, v[15:0]};
            rd  = v;
            lat = mis ? nb + 2 : 3;
        end
    endfunction

    // Called at a negedge; returns at the negedge of the response cycle so the next call is back-to-back.
    task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
        logic e_err, g_err;
        logic [31:0] e_rd, g_rd;
        int e_lat, e_nwe, lat, nwe;
        ref_model(we, op, addr, wd, e_err, e_rd, e_lat, e_nwe);
        chk({tag, "_ready"}, {31'h0, ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        // Junk while busy must be ignored.
        req_valid = (e_lat > 1); req_we = 1'($urandom); req_op = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0; nwe = 0; g_err = 1'b0; g_rd = 32'h0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk);
            log_addr[k] = 32'(mem_addr); log_data[k] = mem_data_in;
            log_op[k] = mem_op; log_we[k] = mem_we;
            if (mem_we) nwe++;
            if (k >= e_lat - 1) req_valid = 1'b0;
            if (resp_valid) begin
                lat = k; g_err = resp_err; g_rd = resp_rdata;
                chk({tag, "_idle_port"}, {13'h0, mem_we, mem_op, mem_addr}, 32'h0);
            end
        end
        req_valid = 1'b0;
        last_rd = g_rd;
        chk({tag, "_lat"}, lat, e_lat);
        chk({tag, "_err"}, {31'h0, g_err}, {31'h0, e_err});
        chk({tag, "_rdata"}, g_rd, e_rd);
        chk({tag, "_nwe"}, nwe, e_nwe);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] ops [0:4];
        logic [31:0] r, ad;
        int bad;
        ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 8'h00;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, ready}, 32'h1);
        chk("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_port", {13'h0, mem_we, mem_op, mem_addr}, 32'h0);
        chk("rst_wdata", mem_data_in, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw_al");
        chk("sw_al_we1", {31'h0, log_we[1]}, 32'h1);
        chk("sw_al_op1", {29'h0, log_op[1]}, 32'h2);
        chk("sw_al_addr1", log_addr[1], 32'h10);
        chk("sw_al_data1", log_data[1], 32'hDEADBEEF);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, "lw_al");
        chk("lw_al_val", last_rd, 32'hDEADBEEF);

        do_req(1'b1, 3'd0, 32'h13, 32'h80, "sb13");
        do_req(1'b0, 3'd0, 32'h13, 32'h0, "lb13");
        chk("lb13_val", last_rd, 32'hFFFFFF80);

        do_req(1'b1, 3'd2, 32'h5, 32'h11223344, "sw_mis");
`ifdef LSU_MISALIGN_SPLIT_EN
        r = 32'h11223344;
        for (int k = 1; k <= 4; k++) begin
            chk("sw_mis_addr", log_addr[k], 32'(4 + k));
            chk("sw_mis_data", log_data[k], {24'h0, r[8*(k-1) +: 8]});
            chk("sw_mis_opwe", {28'h0, log_op[k], log_we[k]}, 32'h1);
        end
`endif

        do_req(1'b1, 3'd0, 32'h7FFF, 32'hF0, "sb_7fff");
        do_req(1'b1, 3'd0, 32'h0, 32'h80, "sb_0");
        do_req(1'b0, 3'd1, 32'h7FFF, 32'h0, "lh_wrap");
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("lh_wrap_a0", log_addr[1], 32'h7FFF);
        chk("lh_wrap_a1", log_addr[2], 32'h0);
        chk("lh_wrap_val", last_rd, 32'hFFFF80F0);
`endif
        do_req(1'b0, 3'd5, 32'h7FFF, 32'h0, "lhu_wrap");
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("lhu_wrap_val", last_rd, 32'h000080F0);
`endif

        do_req(1'b0, 3'd3, 32'h40, 32'h0, "ill_op3");
        do_req(1'b1, 3'd4, 32'h40, 32'hA5, "ill_sbu");
        @(negedge clk);
        chk("ill_pulse", {31'h0, resp_valid}, 32'h0);

        // Reset in the middle of a store: no response and the port goes quiet.
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'd2; req_wdata = 32'h11223344;
        req_addr = SPLIT ? 32'h5 : 32'h20;
        @(posedge clk); #1;
        req_valid = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ref_mem[5] = 8'h44; ref_mem[6] = 8'h33;
`else
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ref_mem[32'h20] = 8'h44; ref_mem[32'h21] = 8'h33; ref_mem[32'h22] = 8'h22; ref_mem[32'h23] = 8'h11;
`endif
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_we || resp_valid || !ready) bad++;
        end
        chk("rst_abort", bad, 0);
        for (int k = 0; k < 4; k++) do_req(1'b0, 3'd4, (SPLIT ? 32'h5 : 32'h20) + 32'(k), 32'h0, "rst_mem");

        for (int n = 0; n < 300; n++) begin
            r  = $urandom;
            ad = {r[16:0], 15'(($urandom_range(0, 1) ? 32'h7FF8 : 32'h0) + $urandom_range(0, 15))};
            do_req(1'($urandom), ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 4)] : 3'($urandom),
                   ad, $urandom, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
